rggen_axi4lite_apb_bridge: RTL and testbench
============================================

RGGEN_AXI4LITE_APB_BRIDGE -- requirements
Module: rggen_axi4lite_apb_bridge

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, 16, byte address width on both sides.
- DATA_WIDTH, 32, data width on both sides; legal values are 32 and 64.
REQ-002 Clock and reset SHALL be a single clock and a synchronous, active-high reset:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
REQ-003 AXI4-Lite write ports SHALL be:
- awvalid/awready  in/out  1  write address handshake.
- awaddr  in  ADDRESS_WIDTH  write address.
- wvalid/wready  in/out  1  write data handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- bvalid/bready  out/in  1  write response handshake.
- bresp  out  2  write response.
REQ-004 AXI4-Lite read ports SHALL be:
- arvalid/arready  in/out  1  read address handshake.
- araddr  in  ADDRESS_WIDTH  read address.
- rvalid/rready  out/in  1  read data handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
REQ-005 APB master ports SHALL be:
- psel, penable, pwrite  out  1.
- paddr  out  ADDRESS_WIDTH.
- pwdata  out  DATA_WIDTH.
- pstrb  out  DATA_WIDTH/8.
- pready, pslverr  in  1.
- prdata  in  DATA_WIDTH.
- This side drives the downstream register block's APB host interface.

Function
REQ-006 FSM SHALL have the states IDLE, SETUP, ACCESS, RESPONSE, and SHALL process exactly one transaction at a time.
REQ-007 In IDLE, a write SHALL be eligible only when awvalid and wvalid are both high; awready and wready SHALL pulse together for one cycle, and one alone SHALL never be accepted.
REQ-008 In IDLE, a read SHALL be eligible when arvalid is high; arready SHALL pulse for one cycle on acceptance.
REQ-009 When a write and a read are eligible in the same cycle, arbitration SHALL alternate:
- The first such conflict after reset grants the write.
- Each later conflict grants the type not granted at the previous conflict.
- Non-conflict grants do not change the arbitration pointer.
REQ-010 On acceptance, the block SHALL register:
- paddr from awaddr or araddr.
- pwrite = 1 for a write.
- pwdata = wdata and pstrb = wstrb for a write.
- pstrb = 0 for a read.
- The FSM moves to SETUP.
REQ-011 In SETUP, psel SHALL be 1 and penable 0 for exactly one cycle, then the FSM SHALL go to ACCESS.
REQ-012 In ACCESS, psel and penable SHALL both be 1; paddr, pwrite, pwdata and pstrb SHALL stay stable until the cycle pready = 1.
REQ-013 On pready = 1 in ACCESS, the block SHALL:
- Capture prdata into rdata for reads.
- Set resp = pslverr ? 2'b10 : 2'b00 into bresp or rresp.
- Drop psel and penable the next cycle.
- Go to RESPONSE.
REQ-014 In RESPONSE, bvalid (write) or rvalid (read) SHALL be high, with data and response held stable, until bready or rready is sampled high; the FSM then SHALL return to IDLE.
REQ-015 Minimum latency, with pready high on the first ACCESS cycle and the master ready, SHALL be:
- Acceptance at cycle 0.
- SETUP at cycle 1.
- ACCESS at cycle 2.
- bvalid/rvalid at cycle 3.
- IDLE at cycle 4.
REQ-016 Ready outputs SHALL be 0 in SETUP, ACCESS and RESPONSE; no new request SHALL be accepted until the FSM is back in IDLE.
REQ-017 bresp and rresp SHALL only ever be 2'b00 or 2'b10; pstrb = 0 during reads.
REQ-018 The block SHALL NOT impose a timeout; ACCESS waits indefinitely for pready.

Reset
REQ-019 While rst = 1, the block SHALL drive:
- State = IDLE.
- psel, penable, pwrite = 0.
- paddr, pwdata, pstrb = 0.
- awready, wready, arready, bvalid, rvalid = 0.
- bresp, rresp, rdata = 0.
- Arbitration pointer = write-first.
REQ-020 Reset asserted in any state, including ACCESS or RESPONSE, SHALL abort the transaction without issuing a response and SHALL apply REQ-019 on the next edge.

Verification
REQ-021 Write: awaddr = 0x0004, wdata = 0xDEADBEEF, wstrb = 0xF, pready = 1 -> APB write to 0x0004 in SETUP at cycle 1 and ACCESS at cycle 2; bvalid at cycle 3 with bresp = 00.
REQ-022 Read with wait states: araddr = 0x0008, pready low for 3 ACCESS cycles, prdata = 0x00010001 -> penable high for 4 cycles with paddr stable; rvalid then shows rdata = 0x00010001, rresp = 00.
REQ-023 Error: read with pslverr = 1 at pready -> rresp = 10; write with pslverr = 1 -> bresp = 10.
REQ-024 Conflict: write and read requested simultaneously, twice in a row -> first grant is the write; second conflict grants the read first.
REQ-025 Partial write request: awvalid = 1, wvalid = 0 for 5 cycles -> awready stays 0 and no APB activity; wvalid = 1 then -> accepted in that cycle.
REQ-026 Reset in ACCESS and back-pressure:
- rst pulsed during ACCESS -> psel = 0 next cycle and no bvalid/rvalid.
- rready held low for 4 cycles -> rvalid and rdata stay stable throughout.

Source files
------------

// File: rtl/rggen_axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge.
// Handles one transaction at a time through IDLE -> SETUP -> ACCESS -> RESPONSE.
// When a write and a read arrive together, the grant alternates between them.
module rggen_axi4lite_apb_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // AXI4-Lite write channels
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  // AXI4-Lite read channels
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  // APB master
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_t;

  state_t state;
  state_t state_next;
  logic   write_first;
  logic   write_eligible;
  logic   read_eligible;
  logic   conflict;
  logic   grant_write;
  logic   grant_read;
  logic   access_done;
  logic   response_taken;

  // A write needs both address and data present; a lone channel is never taken.
  assign write_eligible = awvalid && wvalid;
  assign read_eligible  = arvalid;
  assign conflict       = (state == IDLE) && !rst && write_eligible && read_eligible;
  assign access_done    = (state == ACCESS) && pready;
  assign response_taken = pwrite ? bready : rready;

  // Next-state and grant decode; grants only exist in IDLE and never while in reset.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    grant_write = 1'b0;
    grant_read  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (write_eligible && (!read_eligible || write_first)) begin
            grant_write = 1'b1;
          end else if (read_eligible) begin
            grant_read = 1'b1;
          end
          if (grant_write || grant_read) begin
            state_next = SETUP;
          end
        end
      end
      SETUP:    state_next = ACCESS;
      ACCESS:   if (pready) state_next = RESPONSE;
      RESPONSE: if (response_taken) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign awready = grant_write;
  assign wready  = grant_write;
  assign arready = grant_read;
  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign bvalid  = (state == RESPONSE) && pwrite;
  assign rvalid  = (state == RESPONSE) && !pwrite;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration pointer: flips only when both request types compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_first <= 1'b1;
    end else if (conflict) begin
      write_first <= !write_first;
    end
  end

  // APB request fields latched at acceptance; response fields latched at pready.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
      bresp  <= 2'b00;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else begin
      if (grant_write) begin
        paddr  <= awaddr;
        pwrite <= 1'b1;
        pwdata <= wdata;
        pstrb  <= wstrb;
      end else if (grant_read) begin
        paddr  <= araddr;
        pwrite <= 1'b0;
        pstrb  <= '0;
      end
      if (access_done) begin
        if (pwrite) begin
          bresp <= pslverr ? 2'b10 : 2'b00;
        end else begin
          rresp <= pslverr ? 2'b10 : 2'b00;
          rdata <= prdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_apb_bridge.sv
// Self-checking bench for the AXI4-Lite to APB bridge. The bench plays the AXI
// master and the APB slave; expected values come from the request parameters,
// a word-array register model and a simple alternating-grant rule.
module tb_rggen_axi4lite_apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [15:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [15:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  rggen_axi4lite_apb_bridge #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata)
  );

  // Move to 1 ns after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One complete transaction with APB wait states and response back-pressure.
  // Checks acceptance, SETUP, every ACCESS cycle, every RESPONSE cycle and the
  // return to IDLE against the request it issued.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int waits, input bit err,
                         input logic [31:0] rd_data, input int hold,
                         output int pen_cycles, output logic [1:0] resp_obs,
                         output logic [31:0] rdata_obs);
    logic [1:0]  exp_resp;
    logic [3:0]  exp_strb;
    logic [1:0]  resp_now;
    exp_resp   = err ? 2'b10 : 2'b00;
    exp_strb   = wr ? strb : 4'h0;
    pen_cycles = 0;
    resp_obs   = 2'bxx;
    rdata_obs  = 'x;
    tick();
    awvalid = wr; wvalid = wr; arvalid = !wr;
    awaddr = addr; araddr = addr; wdata = data; wstrb = strb;
    pready = 1'b0; pslverr = 1'b0; bready = 1'b0; rready = 1'b0;
    #1;
    n_checks++;
    if ({awready, wready, arready} !== {wr, wr, !wr}) begin
      n_fail++;
      $display("FAIL accept: aw/w/ar ready=%b expected %b", {awready, wready, arready}, {wr, wr, !wr});
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = ~addr; araddr = ~addr; wdata = ~data; wstrb = ~strb;
    #1;
    n_checks++;
    if ({psel, penable, pwrite, paddr, pstrb} !== {1'b1, 1'b0, wr, addr, exp_strb}) begin
      n_fail++;
      $display("FAIL setup: sel/en/wr/addr/strb=%b/%b/%b/%h/%h expected 1/0/%b/%h/%h",
               psel, penable, pwrite, paddr, pstrb, wr, addr, exp_strb);
    end
    for (int k = 0; k <= waits; k++) begin
      tick();
      pready  = (k == waits);
      pslverr = (k == waits) ? err : !err;
      prdata  = (k == waits) ? rd_data : ~rd_data;
      #1;
      if (penable) pen_cycles++;
      n_checks++;
      if ({psel, penable, pwrite, paddr, pstrb, awready, wready, arready} !==
          {1'b1, 1'b1, wr, addr, exp_strb, 3'b000}) begin
        n_fail++;
        $display("FAIL access%0d: sel/en/wr/addr/strb=%b/%b/%b/%h/%h expected 1/1/%b/%h/%h",
                 k, psel, penable, pwrite, paddr, pstrb, wr, addr, exp_strb);
      end
      if (wr) begin
        n_checks++;
        if (pwdata !== data) begin
          n_fail++;
          $display("FAIL pwdata%0d: got %h expected %h", k, pwdata, data);
        end
      end
    end
    tick();
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    for (int h = 0; h <= hold; h++) begin
      bready = wr && (h == hold);
      rready = !wr && (h == hold);
      #1;
      resp_now = wr ? bresp : rresp;
      if (h == 0) begin
        resp_obs  = resp_now;
        rdata_obs = rdata;
      end
      n_checks++;
      if ({psel, penable, bvalid, rvalid, resp_now} !== {1'b0, 1'b0, wr, !wr, exp_resp}) begin
        n_fail++;
        $display("FAIL response%0d: sel/en/bv/rv/resp=%b/%b/%b/%b/%b expected 0/0/%b/%b/%b",
                 h, psel, penable, bvalid, rvalid, resp_now, wr, !wr, exp_resp);
      end
      if (!wr) begin
        n_checks++;
        if (rdata !== rd_data) begin
          n_fail++;
          $display("FAIL rdata%0d: got %h expected %h", h, rdata, rd_data);
        end
      end
      tick();
    end
    bready = 1'b0; rready = 1'b0;
    #1;
    n_checks++;
    if ({psel, bvalid, rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_return: sel/bv/rv=%b expected 000", {psel, bvalid, rvalid});
    end
  endtask

  task automatic test_reset();
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if ({awready, wready, arready, psel, penable, pwrite, bvalid, rvalid} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {awready, wready, arready, psel, penable, pwrite, bvalid, rvalid});
    end
    n_checks++;
    if ({paddr, pwdata, pstrb, bresp, rresp, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h bresp=%b rresp=%b rdata=%h expected all zero",
               paddr, pwdata, pstrb, bresp, rresp, rdata);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write();
    int pen; logic [1:0] resp; logic [31:0] rd;
    run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0, pen, resp, rd);
    n_checks++;
    if (pen !== 1 || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL write_basic: penable cycles=%0d bresp=%b expected 1 and 00", pen, resp);
    end
  endtask

  task automatic test_read_wait();
    int pen; logic [1:0] resp; logic [31:0] rd;
    run_txn(1'b0, 16'h0008, 32'h0, 4'h0, 3, 1'b0, 32'h00010001, 0, pen, resp, rd);
    n_checks++;
    if (pen !== 4 || resp !== 2'b00 || rd !== 32'h00010001) begin
      n_fail++;
      $display("FAIL read_wait: penable cycles=%0d rresp=%b rdata=%h expected 4, 00, 00010001", pen, resp, rd);
    end
  endtask

  task automatic test_error();
    int pen; logic [1:0] resp; logic [31:0] rd;
    run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 1, 1'b1, 32'h12345678, 0, pen, resp, rd);
    n_checks++;
    if (resp !== 2'b10) begin
      n_fail++;
      $display("FAIL read_error: rresp=%b expected 10", resp);
    end
    run_txn(1'b1, 16'h0014, 32'hCAFEF00D, 4'h5, 0, 1'b1, 32'h0, 0, pen, resp, rd);
    n_checks++;
    if (resp !== 2'b10) begin
      n_fail++;
      $display("FAIL write_error: bresp=%b expected 10", resp);
    end
  endtask

  // A lone read first (must not move the pointer), then write and read held
  // permanently: grants at every fourth cycle must go write, read, write.
  task automatic test_conflict();
    int pen; logic [1:0] resp; logic [31:0] rd;
    bit exp_w, exp_r;
    do_reset();
    run_txn(1'b0, 16'h0020, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 0, pen, resp, rd);
    tick();
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 16'h0030; araddr = 16'h0034; wdata = 32'h55AA55AA; wstrb = 4'hF;
    pready = 1'b1; pslverr = 1'b0; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_w = (c % 4 == 0) && (c / 4 != 1);
      exp_r = (c % 4 == 0) && (c / 4 == 1);
      #1;
      n_checks++;
      if ({awready, wready, arready} !== {exp_w, exp_w, exp_r}) begin
        n_fail++;
        $display("FAIL conflict_c%0d: aw/w/ar ready=%b expected %b", c,
                 {awready, wready, arready}, {exp_w, exp_w, exp_r});
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    pready = 1'b0; bready = 1'b0; rready = 1'b0;
    tick();
  endtask

  task automatic test_partial_write();
    tick();
    awvalid = 1'b1; wvalid = 1'b0; awaddr = 16'h0040; wdata = 32'hA5A5A5A5; wstrb = 4'h3;
    pready = 1'b1; bready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({awready, wready, psel, penable} !== 4'b0000) begin
        n_fail++;
        $display("FAIL partial_c%0d: aw/w ready, sel, en=%b expected 0000", c,
                 {awready, wready, psel, penable});
      end
      tick();
    end
    wvalid = 1'b1;
    #1;
    n_checks++;
    if ({awready, wready} !== 2'b11) begin
      n_fail++;
      $display("FAIL partial_accept: aw/w ready=%b expected 11", {awready, wready});
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL partial_resp: bvalid/bresp=%b expected 100", {bvalid, bresp});
    end
    tick();
    pready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_reset_in_access();
    tick();
    arvalid = 1'b1; araddr = 16'h0050; pready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    #1;
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_pre: sel/en=%b expected 11", {psel, penable});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; pready = 1'b1; pslverr = 1'b0; rready = 1'b1; bready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({psel, penable, bvalid, rvalid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL abort_c%0d: sel/en/bv/rv=%b expected 0000", c, {psel, penable, bvalid, rvalid});
      end
      tick();
    end
    pready = 1'b0; rready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_backpressure();
    int pen; logic [1:0] resp; logic [31:0] rd;
    logic [31:0] val;
    val = $urandom;
    run_txn(1'b0, 16'h0060, 32'h0, 4'h0, 0, 1'b0, val, 4, pen, resp, rd);
    n_checks++;
    if (rd !== val) begin
      n_fail++;
      $display("FAIL backpressure: rdata=%h expected %h", rd, val);
    end
  endtask

  // Random mix against a word-addressed register model: APB writes merge bytes
  // into the model, APB reads answer from it and the AXI side must echo it.
  task automatic test_random();
    int pen; logic [1:0] resp; logic [31:0] rd;
    bit wr, err;
    int idx, waits, hold;
    logic [31:0] data;
    logic [3:0] strb;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int t = 0; t < 24; t++) begin
      wr    = $urandom_range(0, 1) == 1;
      err   = $urandom_range(0, 7) == 0;
      idx   = $urandom_range(0, 15);
      waits = $urandom_range(0, 3);
      hold  = $urandom_range(0, 2);
      data  = $urandom;
      strb  = 4'($urandom_range(0, 15));
      run_txn(wr, 16'(idx * 4), data, strb, waits, err, mem[idx], hold, pen, resp, rd);
      n_checks++;
      if (pen !== waits + 1) begin
        n_fail++;
        $display("FAIL random%0d_access_len: penable cycles=%0d expected %0d", t, pen, waits + 1);
      end
      if (wr && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mem[idx][b*8 +: 8] = data[b*8 +: 8];
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_conflict();
    test_partial_write();
    test_reset_in_access();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
